// File: rtl/bk_ctrl.sv
// bk_ctrl: backup-RAM save/load sequencer.
// Picks one of four transfer triggers (auto-load after download, OSD load,
// OSD save, OSD-open autosave), walks SECTORS 512-byte sectors over the
// sd_rd/sd_wr/sd_ack handshake, tracks nvram dirtiness and aborts any
// sector that does not finish within TIMEOUT cycles.
module bk_ctrl #(
    parameter int unsigned SECTORS = 64,
    parameter logic [23:0] TIMEOUT = 24'd8000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        downloading,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        img_size_nz,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        autosave_en,
    input  logic        osd_status,
    input  logic        nvram_we,
    input  logic        sd_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        bk_ena,
    output logic        bk_loading,
    output logic        bk_busy,
    output logic        dirty,
    output logic        err
);

    // A single-sector image still needs a one-bit address register.
    localparam int unsigned    LBA_W    = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ACK   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t           state_q,   state_d;
    logic [LBA_W-1:0] lba_q,     lba_d;
    logic [23:0]      timer_q,   timer_d;
    logic             rd_q,      rd_d;
    logic             wr_q,      wr_d;
    logic             ena_q,     ena_d;
    logic             loading_q, loading_d;
    logic             busy_q,    busy_d;
    logic             dirty_q,   dirty_d;
    logic             err_q,     err_d;
    logic             op_load_q, op_load_d;

    // Edge-detect history.
    logic dl_prev_q,  dl_prev_d;
    logic ack_prev_q, ack_prev_d;
    logic ld_prev_q,  ld_prev_d;
    logic sv_prev_q,  sv_prev_d;
    logic osd_prev_q, osd_prev_d;

    logic        dl_rise_s, dl_fall_s, ack_rise_s, ack_fall_s, osd_rise_s;
    logic        ld_lvl_s, sv_lvl_s;
    logic        trig_auto_s, trig_load_s, trig_save_s, trig_asv_s;
    logic        dirty_clr_s;
    logic [23:0] timer_inc_s;
    logic        timed_out_s;

    assign dl_rise_s  =  downloading & ~dl_prev_q;
    assign dl_fall_s  = ~downloading &  dl_prev_q;
    assign ack_rise_s =  sd_ack      & ~ack_prev_q;
    assign ack_fall_s = ~sd_ack      &  ack_prev_q;
    assign osd_rise_s =  osd_status  & ~osd_prev_q;
    assign ld_lvl_s   =  load_req & ena_q;
    assign sv_lvl_s   =  save_req & ena_q;

    assign trig_auto_s = dl_fall_s & ena_q & img_size_nz;
    assign trig_load_s = ld_lvl_s & ~ld_prev_q;
    assign trig_save_s = sv_lvl_s & ~sv_prev_q;
    assign trig_asv_s  = osd_rise_s & autosave_en & dirty_q & ena_q;

    assign timed_out_s = (timer_q == TIMEOUT);
    assign timer_inc_s = timed_out_s ? timer_q : (timer_q + 24'd1);

    // Next-state logic: trigger arbitration, sector sequencing, status flags.
    always_comb begin
        state_d     = state_q;
        lba_d       = lba_q;
        timer_d     = timer_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        loading_d   = loading_q;
        busy_d      = busy_q;
        err_d       = err_q;
        op_load_d   = op_load_q;
        dirty_clr_s = 1'b0;
        dl_prev_d   = downloading;
        ack_prev_d  = sd_ack;
        ld_prev_d   = ld_lvl_s;
        sv_prev_d   = sv_lvl_s;
        osd_prev_d  = osd_status;

        // Set beats clear when a new download both starts and mounts at once.
        if (downloading && img_mounted && !img_readonly) begin
            ena_d = 1'b1;
        end else if (dl_rise_s) begin
            ena_d = 1'b0;
        end else begin
            ena_d = ena_q;
        end

        case (state_q)
            S_IDLE: begin
                if (trig_auto_s || trig_load_s || trig_save_s || trig_asv_s) begin
                    // Loads outrank saves; losers are dropped, not queued.
                    op_load_d   = trig_auto_s | trig_load_s;
                    state_d     = S_REQ;
                    lba_d       = '0;
                    timer_d     = 24'd0;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    loading_d   = trig_auto_s | trig_load_s;
                    rd_d        = trig_auto_s | trig_load_s;
                    wr_d        = ~(trig_auto_s | trig_load_s);
                    dirty_clr_s = ~(trig_auto_s | trig_load_s);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ack_rise_s) begin
                    state_d = S_ACK;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    timer_d = timer_inc_s;
                end else if (timed_out_s) begin
                    state_d = S_ABORT;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            S_ACK: begin
                if (ack_fall_s) begin
                    if (lba_q == LBA_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        lba_d   = lba_q + LBA_W'(1);
                        timer_d = 24'd0;
                        rd_d    = op_load_q;
                        wr_d    = ~op_load_q;
                    end
                end else if (timed_out_s) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                loading_d   = 1'b0;
                dirty_clr_s = op_load_q;
            end
            S_ABORT: begin
                state_d   = S_IDLE;
                rd_d      = 1'b0;
                wr_d      = 1'b0;
                busy_d    = 1'b0;
                loading_d = 1'b0;
                err_d     = 1'b1;
            end
            default: begin
                state_d   = S_IDLE;
                rd_d      = 1'b0;
                wr_d      = 1'b0;
                busy_d    = 1'b0;
                loading_d = 1'b0;
            end
        endcase

        // A write during a save must survive that save; writes during a load
        // are the load itself and never mark the buffer dirty.
        if (nvram_we && !loading_q) begin
            dirty_d = 1'b1;
        end else if (dirty_clr_s) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // State and output registers; reset primes edge history with live inputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lba_q      <= '0;
            timer_q    <= 24'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ena_q      <= 1'b0;
            loading_q  <= 1'b0;
            busy_q     <= 1'b0;
            dirty_q    <= 1'b0;
            err_q      <= 1'b0;
            op_load_q  <= 1'b0;
            dl_prev_q  <= downloading;
            ack_prev_q <= sd_ack;
            osd_prev_q <= osd_status;
            // The gated request levels are 0 while bk_ena is 0 after reset.
            ld_prev_q  <= 1'b0;
            sv_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lba_q      <= lba_d;
            timer_q    <= timer_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ena_q      <= ena_d;
            loading_q  <= loading_d;
            busy_q     <= busy_d;
            dirty_q    <= dirty_d;
            err_q      <= err_d;
            op_load_q  <= op_load_d;
            dl_prev_q  <= dl_prev_d;
            ack_prev_q <= ack_prev_d;
            ld_prev_q  <= ld_prev_d;
            sv_prev_q  <= sv_prev_d;
            osd_prev_q <= osd_prev_d;
        end
    end

    assign sd_lba     = 32'(lba_q);
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = ena_q;
    assign bk_loading = loading_q;
    assign bk_busy    = busy_q;
    assign dirty      = dirty_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bk_ctrl.sv
// tb_bk_ctrl: table-driven per-cycle vectors for bk_ena/trigger gating,
// then hand-written sequences for full transfers, priority, timeout and
// reset during a transfer.
module tb_bk_ctrl;

    localparam int unsigned SECTORS = 64;

    logic        clk_sys = 1'b0;
    logic        reset, downloading, img_mounted, img_readonly, img_size_nz;
    logic        load_req, save_req, autosave_en, osd_status, nvram_we, sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, dirty, err;

    int checks = 0;
    int errors = 0;

    bk_ctrl #(.SECTORS(SECTORS), .TIMEOUT(24'd100)) dut (
        .clk_sys(clk_sys), .reset(reset), .downloading(downloading),
        .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size_nz(img_size_nz), .load_req(load_req), .save_req(save_req),
        .autosave_en(autosave_en), .osd_status(osd_status),
        .nvram_we(nvram_we), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .bk_ena(bk_ena), .bk_loading(bk_loading),
        .bk_busy(bk_busy), .dirty(dirty), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic rst, dl, mnt, ro, nz, ld, sv, asv, osd, we;
        logic e_ena, e_busy, e_load, e_dirty, e_err, e_rd, e_wr;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Service nsec sectors starting at lba 0; optionally pulse nvram_we or
    // raise save_req at a given sector.
    task automatic serve(input bit is_rd, input int we_lba, input int sv_lba, input int nsec);
        for (int i = 0; i < nsec; i++) begin
            int n = 0;
            while (!(is_rd ? sd_rd : sd_wr) && n < 20) begin
                tick();
                n++;
            end
            chk("req_seen", 32'(is_rd ? sd_rd : sd_wr), 32'd1);
            chk("sector_lba", sd_lba, 32'(i));
            chk("other_line", 32'(is_rd ? sd_wr : sd_rd), 32'd0);
            chk("loading_in_xfer", 32'(bk_loading), 32'(is_rd));
            if (i == we_lba) nvram_we = 1'b1;
            if (i == sv_lba) save_req = 1'b1;
            sd_ack = 1'b1;
            tick();
            nvram_we = 1'b0;
            chk("req_drop", 32'(is_rd ? sd_rd : sd_wr), 32'd0);
            tick();
            sd_ack = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; downloading = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
        img_size_nz = 1'b0; load_req = 1'b0; save_req = 1'b0; autosave_en = 1'b0;
        osd_status = 1'b0; nvram_we = 1'b0; sd_ack = 1'b0;

        //          rst   dl    mnt   ro    nz    ld    sv    asv   osd   we  | ena  busy load dirty err  rd   wr
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};

        #1;
        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst;  downloading = vecs[i].dl; img_mounted = vecs[i].mnt;
            img_readonly = vecs[i].ro; img_size_nz = vecs[i].nz; load_req = vecs[i].ld;
            save_req = vecs[i].sv; autosave_en = vecs[i].asv; osd_status = vecs[i].osd;
            nvram_we = vecs[i].we;
            tick();
            chk($sformatf("v%0d_ena", i),   32'(bk_ena),     32'(vecs[i].e_ena));
            chk($sformatf("v%0d_busy", i),  32'(bk_busy),    32'(vecs[i].e_busy));
            chk($sformatf("v%0d_load", i),  32'(bk_loading), 32'(vecs[i].e_load));
            chk($sformatf("v%0d_dirty", i), 32'(dirty),      32'(vecs[i].e_dirty));
            chk($sformatf("v%0d_err", i),   32'(err),        32'(vecs[i].e_err));
            chk($sformatf("v%0d_rd", i),    32'(sd_rd),      32'(vecs[i].e_rd));
            chk($sformatf("v%0d_wr", i),    32'(sd_wr),      32'(vecs[i].e_wr));
            chk($sformatf("v%0d_lba", i),   sd_lba,          32'd0);
        end

        // Autosave just started: run it, write nvram at sector 10.
        serve(1'b0, 10, -1, SECTORS);
        chk("asv_done_busy", 32'(bk_busy), 32'd1);
        tick();
        chk("asv_idle_busy", 32'(bk_busy), 32'd0);
        chk("asv_dirty_kept", 32'(dirty), 32'd1);
        chk("asv_wr_low", 32'(sd_wr), 32'd0);
        osd_status = 1'b0; autosave_en = 1'b0;

        // Auto-load after a download; save_req rises mid-load and is ignored.
        downloading = 1'b1; img_mounted = 1'b1; img_readonly = 1'b0;
        tick();
        chk("al_ena_set", 32'(bk_ena), 32'd1);
        img_mounted = 1'b0;
        tick();
        downloading = 1'b0; img_size_nz = 1'b1;
        tick();
        chk("al_start_rd", 32'(sd_rd), 32'd1);
        chk("al_start_loading", 32'(bk_loading), 32'd1);
        chk("al_start_busy", 32'(bk_busy), 32'd1);
        serve(1'b1, 20, 30, SECTORS);
        chk("al_done_loading", 32'(bk_loading), 32'd1);
        tick();
        chk("al_end_loading", 32'(bk_loading), 32'd0);
        chk("al_end_busy", 32'(bk_busy), 32'd0);
        chk("al_dirty_clear", 32'(dirty), 32'd0);
        tick(); tick();
        chk("mid_save_ignored_wr", 32'(sd_wr), 32'd0);
        chk("mid_save_ignored_busy", 32'(bk_busy), 32'd0);
        img_size_nz = 1'b0; save_req = 1'b0;
        tick();

        // load_req and save_req rise together: load wins.
        load_req = 1'b1; save_req = 1'b1;
        tick();
        chk("prio_rd", 32'(sd_rd), 32'd1);
        chk("prio_wr", 32'(sd_wr), 32'd0);
        serve(1'b1, -1, -1, SECTORS);
        tick();
        chk("prio_end_busy", 32'(bk_busy), 32'd0);
        chk("prio_no_save", 32'(sd_wr), 32'd0);
        load_req = 1'b0; save_req = 1'b0;
        tick();

        // OSD save with dirty data.
        nvram_we = 1'b1;
        tick();
        nvram_we = 1'b0;
        chk("we_dirty", 32'(dirty), 32'd1);
        save_req = 1'b1;
        tick();
        chk("save_wr", 32'(sd_wr), 32'd1);
        chk("save_dirty_clr", 32'(dirty), 32'd0);
        serve(1'b0, -1, -1, SECTORS);
        tick();
        chk("save_end_busy", 32'(bk_busy), 32'd0);
        chk("save_end_dirty", 32'(dirty), 32'd0);
        save_req = 1'b0;
        tick();

        // Autosave with clean buffer does nothing.
        autosave_en = 1'b1;
        tick();
        osd_status = 1'b1;
        tick();
        chk("asv_clean_busy", 32'(bk_busy), 32'd0);
        tick();
        chk("asv_clean_wr", 32'(sd_wr), 32'd0);
        osd_status = 1'b0; autosave_en = 1'b0;

        // Timeout: ack never comes.
        load_req = 1'b1;
        tick();
        chk("to_start_rd", 32'(sd_rd), 32'd1);
        n = 0;
        while (!err && n < 300) begin
            tick();
            n++;
            if (n == 90) chk("to_not_early", 32'(sd_rd), 32'd1);
        end
        chk("to_cycles", 32'(n), 32'd102);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rd", 32'(sd_rd), 32'd0);
        chk("to_loading", 32'(bk_loading), 32'd0);
        chk("to_busy", 32'(bk_busy), 32'd0);
        load_req = 1'b0;
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        load_req = 1'b1;
        tick();
        chk("err_clr_on_start", 32'(err), 32'd0);
        chk("reload_rd", 32'(sd_rd), 32'd1);

        // Reset at sector 5 of a load; held load_req must not restart.
        serve(1'b1, -1, -1, 5);
        chk("rst_at_lba", sd_lba, 32'd5);
        reset = 1'b1;
        tick();
        chk("rst_rd", 32'(sd_rd), 32'd0);
        chk("rst_busy", 32'(bk_busy), 32'd0);
        chk("rst_loading", 32'(bk_loading), 32'd0);
        chk("rst_ena", 32'(bk_ena), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_busy", 32'(bk_busy), 32'd0);
        chk("post_rst_rd", 32'(sd_rd), 32'd0);
        load_req = 1'b0;

        // Autosave with bk_ena=0 does nothing even when dirty.
        nvram_we = 1'b1;
        tick();
        nvram_we = 1'b0;
        chk("noena_dirty", 32'(dirty), 32'd1);
        autosave_en = 1'b1;
        tick();
        osd_status = 1'b1;
        tick();
        chk("noena_busy", 32'(bk_busy), 32'd0);
        tick();
        chk("noena_wr", 32'(sd_wr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bk_ctrl.md
Name: bk_ctrl

Overview:
- Backup-RAM save/load sequencer between the console core's nvram dual-port buffer and the hps_io SD sector interface.
- Arbitrates four transfer sources (post-download auto-load, OSD load, OSD save, OSD-open autosave) and sequences a fixed block of 512-byte sectors over sd_rd/sd_wr/sd_ack.
- Tracks whether nvram contents are dirty and exposes bk_loading, which the top level ORs into system reset.
- Includes an ack watchdog so a lost transfer cannot hang the core.

Parameters:
SECTORS, 64, number of 512-byte sectors per image; power of two, 1..256
TIMEOUT, 24'd8000000, clk_sys cycles allowed per sector before abort

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous active-high reset; driven by the top-level RESET only, never by bk_loading
downloading  in  1  ioctl_download
img_mounted  in  1  hps_io image-mounted strobe
img_readonly  in  1  mounted image is read-only
img_size_nz  in  1  mounted image size is non-zero
load_req  in  1  OSD load level; a rising edge triggers a load
save_req  in  1  OSD save level; a rising edge triggers a save
autosave_en  in  1  autosave enabled
osd_status  in  1  OSD open
nvram_we  in  1  core write strobe into nvram
sd_ack  in  1  hps_io sector acknowledge
sd_lba  out  32  sector address; bits above log2(SECTORS) are always 0
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  save file available
bk_loading  out  1  load in progress
bk_busy  out  1  any transfer in progress
dirty  out  1  nvram modified since the last load or save start
err  out  1  sticky timeout flag

Behaviour:
- All registers update on posedge clk_sys. Edge detectors compare each input against its value on the previous cycle.
- Reset values: every output is 0; state is IDLE. All edge-detect history registers are loaded with their current input value, so no edge is seen on the first cycle after reset.
- Reset during a transfer: the transfer is abandoned, sd_rd and sd_wr drop the next cycle, and no completion side effects occur.
- bk_ena:
  - A rising edge of downloading clears it.
  - While downloading=1, img_mounted=1 and img_readonly=0, it is set.
  - If both happen in the same cycle, set wins.
- Trigger conditions and priority, checked only in IDLE, highest first:
  1. auto-load: falling edge of downloading while bk_ena=1 and img_size_nz=1.
  2. load: rising edge of (load_req & bk_ena).
  3. save: rising edge of (save_req & bk_ena).
  4. autosave: rising edge of osd_status while autosave_en=1, dirty=1, bk_ena=1.
- Lower-priority triggers that coincide with a higher one are dropped, not queued. Triggers arriving while not in IDLE are ignored.
- Transfer start:
  - sd_lba=0; bk_busy=1; timer=0.
  - bk_loading=1 for loads and auto-loads.
  - Asserts sd_rd for a load, sd_wr for a save; enters REQ.
  - A save start clears dirty.
- REQ state:
  - The request line is held high until the first cycle sd_ack=1; the line clears the cycle after the sd_ack rising edge is seen. Then go to ACK.
  - If timer reaches TIMEOUT before the sd_ack rising edge, go to ABORT.
- ACK state:
  - On the sd_ack falling edge:
    - if sd_lba==SECTORS-1, go to DONE;
    - else sd_lba+1, timer=0, reassert the same request line, return to REQ.
  - If timer reaches TIMEOUT before the falling edge, go to ABORT.
- DONE: one cycle. Clears bk_busy and bk_loading; a load also clears dirty. Then IDLE.
- ABORT: one cycle. Clears sd_rd, sd_wr, bk_busy and bk_loading; sets err. Then IDLE. err clears only on reset or on the next transfer start.
- timer: increments in REQ and ACK, saturates at TIMEOUT, and is cleared on each sector advance.
- dirty:
  - Set by nvram_we when bk_loading=0.
  - nvram_we during a save re-sets dirty; the later DONE does not clear it.
  - nvram_we during a load is ignored.
- sd_lba is held constant between advances. At most one of sd_rd/sd_wr is ever high.

Test Plan:
- Auto-load: reset; downloading 1; img_mounted pulse with img_readonly=0; downloading 0 with img_size_nz=1 -> bk_ena=1, sd_rd pulses 64 times for lba 0..63, bk_loading=1 throughout and 0 one cycle after the 64th ack falls, sd_wr stays 0.
- Save and dirty: nvram_we pulse -> dirty=1; save_req rising -> dirty=0 at start, sd_wr for lba 0..63; nvram_we at lba 10 -> dirty=1 after DONE.
- Priority and ignore: load_req and save_req rise in the same cycle -> load only. save_req rising mid-load -> ignored, no sd_wr ever.
- Autosave gating: dirty=1, autosave_en=1, osd_status rises -> save runs. Same with dirty=0 or autosave_en=0 -> nothing. With bk_ena=0 -> nothing.
- Timeout: TIMEOUT=100, sd_ack never rises -> ABORT at timer=100, err=1, sd_rd=0, bk_loading=0; the next load_req rising edge clears err.
- Reset mid-transfer: assert reset at lba 5 during a load -> the next cycle has all outputs 0, bk_ena=0, dirty=0; a load_req level already held high produces no start after reset releases.
